ccip_mmio_rd_responder: RTL

//  AFU-side responder for host MMIO reads on CCI-P. Buffers incoming c0 MMIO read requests
//  (up to MAX_OUTSTANDING), issues them in order to a CSR read backend and returns each

---
 rtl/ccip_mmio_rd_responder.sv | 118 +++++++++++
 1 files changed

// File: rtl/ccip_mmio_rd_responder.sv
// CCI-P MMIO read responder: queues host c0 MMIO reads, issues them in order to a CSR
// read backend, and returns each result on c2 with the original tid.
`timescale 1ns/1ps
module ccip_mmio_rd_responder #(
  parameter int MAX_OUTSTANDING = 64,
  parameter int ADDR_W          = 16,
  parameter int TID_W           = 9,
  parameter int DATA_W          = 64
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 rx_mmio_rd_valid,
  input  logic [ADDR_W-1:0]                    rx_mmio_rd_addr,
  input  logic [TID_W-1:0]                     rx_mmio_rd_tid,
  input  logic [1:0]                           rx_mmio_rd_len,
  output logic                                 csr_rd_req_valid,
  output logic [ADDR_W-1:0]                    csr_rd_req_addr,
  input  logic                                 csr_rd_req_ready,
  input  logic                                 csr_rd_rsp_valid,
  input  logic [DATA_W-1:0]                    csr_rd_rsp_data,
  output logic                                 csr_rd_rsp_ready,
  output logic                                 tx_c2_rsp_valid,
  output logic [TID_W-1:0]                     tx_c2_rsp_tid,
  output logic [DATA_W-1:0]                    tx_c2_rsp_data,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_cnt,
  output logic                                 err_overflow,
  output logic                                 err_bad_len
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);
  localparam logic [PTR_W:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  // REQ queue: admitted requests waiting for the backend
  logic [ADDR_W-1:0] req_addr_mem [MAX_OUTSTANDING];
  logic [TID_W-1:0]  req_tid_mem  [MAX_OUTSTANDING];
  logic              req_bad_mem  [MAX_OUTSTANDING];
  logic [PTR_W:0]    req_wr, req_rd;

  // INFL queue: requests at the backend (or bad ones) waiting to be answered
  logic [TID_W-1:0]  infl_tid_mem [MAX_OUTSTANDING];
  logic              infl_bad_mem [MAX_OUTSTANDING];
  logic [PTR_W:0]    infl_wr, infl_rd;

  logic req_empty, infl_empty, req_head_bad, infl_head_bad;
  logic admit, req_pop, infl_pop, len_bad;

  // Handshakes: a transfer happens in a cycle where valid and ready are both high at the
  // clock edge. Valid never depends on ready; rx and c2 strobes carry no backpressure.
  always_comb begin
    req_empty     = (req_wr == req_rd);
    infl_empty    = (infl_wr == infl_rd);
    req_head_bad  = req_bad_mem[req_rd[PTR_W-1:0]];
    infl_head_bad = infl_bad_mem[infl_rd[PTR_W-1:0]];
    len_bad       = rx_mmio_rd_len[1];
    // Admission uses the pre-update count; a same-cycle departure is not credited.
    admit         = rx_mmio_rd_valid && (outstanding_cnt < CNT_MAX);
    req_pop       = !req_empty && (req_head_bad || csr_rd_req_ready);
    infl_pop      = !infl_empty && (infl_head_bad || csr_rd_rsp_valid);

    csr_rd_req_valid = !req_empty && !req_head_bad;
    csr_rd_req_addr  = csr_rd_req_valid ? req_addr_mem[req_rd[PTR_W-1:0]] : '0;
    csr_rd_rsp_ready = !infl_empty && !infl_head_bad;
  end

  always_ff @(posedge clk) begin
    if (admit) begin
      req_addr_mem[req_wr[PTR_W-1:0]] <= rx_mmio_rd_addr;
      req_tid_mem[req_wr[PTR_W-1:0]]  <= rx_mmio_rd_tid;
      req_bad_mem[req_wr[PTR_W-1:0]]  <= len_bad;
    end
    if (req_pop) begin
      infl_tid_mem[infl_wr[PTR_W-1:0]] <= req_tid_mem[req_rd[PTR_W-1:0]];
      infl_bad_mem[infl_wr[PTR_W-1:0]] <= req_head_bad;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_wr          <= '0;
      req_rd          <= '0;
      infl_wr         <= '0;
      infl_rd         <= '0;
      outstanding_cnt <= '0;
      err_overflow    <= 1'b0;
      err_bad_len     <= 1'b0;
      tx_c2_rsp_valid <= 1'b0;
      tx_c2_rsp_tid   <= '0;
      tx_c2_rsp_data  <= '0;
    end else begin
      if (admit) req_wr <= req_wr + PTR_ONE;
      if (req_pop) begin
        req_rd  <= req_rd + PTR_ONE;
        infl_wr <= infl_wr + PTR_ONE;
      end
      if (infl_pop) infl_rd <= infl_rd + PTR_ONE;

      case ({admit, infl_pop})
        2'b10:   outstanding_cnt <= outstanding_cnt + CNT_ONE;
        2'b01:   outstanding_cnt <= outstanding_cnt - CNT_ONE;
        default: outstanding_cnt <= outstanding_cnt;
      endcase

      if (rx_mmio_rd_valid && !admit) err_overflow <= 1'b1;
      if (admit && len_bad)           err_bad_len  <= 1'b1;

      // Bad-length entries are answered with zero data instead of backend data.
      tx_c2_rsp_valid <= infl_pop;
      if (infl_pop) begin
        tx_c2_rsp_tid  <= infl_tid_mem[infl_rd[PTR_W-1:0]];
        tx_c2_rsp_data <= infl_head_bad ? '0 : csr_rd_rsp_data;
      end
    end
  end

endmodule
